// File: rtl/dmem_arbiter.sv
// Two-port front end for the 128-word data memory. It arbitrates by round-robin
// or fixed priority, performs sub-word stores as read-modify-write and extends sub-word loads.
module dmem_arbiter #(
  parameter int ADDR_W     = 9,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [1:0]        p0_size,
  input  logic              p0_unsigned,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [31:0]       p0_wdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [1:0]        p1_size,
  input  logic              p1_unsigned,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [31:0]       p1_wdata,
  output logic              p0_ack,
  output logic              p0_err,
  output logic [31:0]       p0_rdata,
  output logic              p1_ack,
  output logic              p1_err,
  output logic [31:0]       p1_rdata,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [8:0]        mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic              grant
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, WRITE = 2'd2, RESP = 2'd3} state_t;

  state_t              state_r, state_s;
  logic                last_r, grant_r, we_r, uns_r, err_r;
  logic [1:0]          size_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [31:0]         wdata_r, mem_wdata_r, p0_rdata_r, p1_rdata_r;
  logic                any_req_s, win_s, sel_we_s, sel_uns_s, illegal_s;
  logic [1:0]          sel_size_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [31:0]         sel_wdata_s, load_s, merge_s;

  function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] lane);
    logic r;
    case (size)
      2'b00:   r = 1'b0;
      2'b01:   r = lane[0];
      2'b10:   r = (lane != 2'b00);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  // Byte/half lanes of the old word are replaced by the low bits of the store data.
  function automatic logic [31:0] merge_word(input logic [31:0] old, input logic [31:0] wd,
                                             input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] m;
    m = old;
    case (size)
      2'b00:   m[{lane, 3'b000} +: 8] = wd[7:0];
      2'b01:   m[{lane[1], 4'b0000} +: 16] = wd[15:0];
      default: m = wd;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] size,
                                           input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{lane, 3'b000} +: 8];
    h = w[{lane[1], 4'b0000} +: 16];
    case (size)
      2'b00:   r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Winner selection and the fields of the winning request.
  always_comb begin
    any_req_s = p0_req | p1_req;
    if (p0_req && p1_req) begin
      win_s = FIXED_PRIO ? 1'b0 : ~last_r;
    end else if (p1_req) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
    sel_we_s    = win_s ? p1_we       : p0_we;
    sel_size_s  = win_s ? p1_size     : p0_size;
    sel_uns_s   = win_s ? p1_unsigned : p0_unsigned;
    sel_addr_s  = win_s ? p1_addr     : p0_addr;
    sel_wdata_s = win_s ? p1_wdata    : p0_wdata;
    illegal_s   = is_illegal(sel_size_s, sel_addr_s[1:0]);
    load_s      = load_ext(mem_rdata, size_r, addr_r[1:0], uns_r);
    merge_s     = merge_word(mem_rdata, wdata_r, size_r, addr_r[1:0]);
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          state_s = illegal_s ? RESP : ACCESS;
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS:  state_s = we_r ? WRITE : RESP;
      WRITE:   state_s = RESP;
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, request latch, read data and merged write word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      last_r      <= 1'b1;
      grant_r     <= 1'b0;
      we_r        <= 1'b0;
      uns_r       <= 1'b0;
      err_r       <= 1'b0;
      size_r      <= 2'b00;
      addr_r      <= '0;
      wdata_r     <= 32'h0000_0000;
      mem_wdata_r <= 32'h0000_0000;
      p0_rdata_r  <= 32'h0000_0000;
      p1_rdata_r  <= 32'h0000_0000;
    end else begin
      state_r <= state_s;
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            grant_r <= win_s;
            we_r    <= sel_we_s;
            size_r  <= sel_size_s;
            uns_r   <= sel_uns_s;
            addr_r  <= sel_addr_s;
            wdata_r <= sel_wdata_s;
            err_r   <= illegal_s;
            // An erroring request returns zero data on its port.
            if (illegal_s && win_s) begin
              p1_rdata_r <= 32'h0000_0000;
            end else if (illegal_s) begin
              p0_rdata_r <= 32'h0000_0000;
            end
          end
        end
        ACCESS: begin
          if (we_r) begin
            mem_wdata_r <= merge_s;
          end else if (grant_r) begin
            p1_rdata_r <= load_s;
          end else begin
            p0_rdata_r <= load_s;
          end
        end
        RESP:    last_r <= grant_r;
        default: ;
      endcase
    end
  end

  assign busy      = (state_r != IDLE);
  assign grant     = grant_r;
  assign MemRead   = (state_r == ACCESS);
  assign MemWrite  = (state_r == WRITE);
  assign mem_addr  = {2'b00, addr_r[8:2]};
  assign mem_wdata = mem_wdata_r;
  assign p0_ack    = (state_r == RESP) && !grant_r;
  assign p1_ack    = (state_r == RESP) && grant_r;
  assign p0_err    = p0_ack && err_r;
  assign p1_err    = p1_ack && err_r;
  assign p0_rdata  = p0_rdata_r;
  assign p1_rdata  = p1_rdata_r;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port controller and arbiter in front of the 128-word data memory (combinational read, level-sensitive write). It shares the memory between the core load/store unit (port 0) and the debug/loader port (port 1). It also sequences byte and halfword stores as read-modify-write, and sign- or zero-extends sub-word loads. It is the only driver of the memory's MemRead, MemWrite, addr and write_data inputs.

## Interface
- ADDR_W, 9, requester byte-address width; the memory word index is addr[8:2].
- FIXED_PRIO, 0, 0 = round-robin between ports; 1 = port 0 always wins.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- p0_req, p1_req  in  1  request; held high with stable fields until ack.
- p0_we, p1_we  in  1  1 = store, 0 = load.
- p0_size, p1_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- p0_unsigned, p1_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- p0_addr, p1_addr  in  ADDR_W  byte address, little-endian lanes.
- p0_wdata, p1_wdata  in  32  store data; byte uses [7:0], half uses [15:0].
- p0_ack, p1_ack  out  1  one-cycle completion pulse.
- p0_err, p1_err  out  1  valid with ack; 1 = misaligned or illegal size.
- p0_rdata, p1_rdata  out  32  load result; valid with ack, held until the next ack on that port.
- MemRead  out  1  memory read enable.
- MemWrite  out  1  memory write enable.
- mem_addr  out  9  {2'b00, addr[8:2]}.
- mem_wdata  out  32  merged write word.
- mem_rdata  in  32  memory read data, combinational.
- busy  out  1  state != IDLE.
- grant  out  1  port currently owning the transaction.

## Operation
- FSM states: IDLE, ACCESS, WRITE, RESP.
- **IDLE**
  - Arbitrate among asserted reqs.
    - Round-robin: the port not granted last wins a tie.
    - The last-grant pointer resets to 1, so port 0 wins the first tie.
  - Latch the winner's we, size, unsigned, addr and wdata; set grant.
  - Illegal request → RESP with err = 1, no memory access. Illegal means:
    - size = 11;
    - half with addr[0] = 1;
    - word with addr[1:0] != 00.
  - Otherwise → ACCESS.
- **ACCESS**
  - MemRead = 1, mem_addr driven from the latched address.
  - Load:
    - Select lane (byte: addr[1:0]; half: addr[1]).
    - Extend per unsigned; a word passes through unchanged.
    - Register into rdata → RESP.
  - Store:
    - Word: merged word = wdata.
    - Byte/half: replace only the addressed lane(s) of mem_rdata with the low bits of wdata.
    - Register the merged word into mem_wdata → WRITE.
- **WRITE**
  - MemWrite = 1, MemRead = 0 for exactly one cycle.
  - mem_addr and mem_wdata are stable from registers for the whole cycle → RESP.
- **RESP**
  - Pulse ack on the granted port, with err.
  - Update the last-grant pointer → IDLE.
- The non-granted port's req stays pending; it is serviced in a following IDLE.
- Memory-side outputs come from registers or state decode only, with no combinational path from requester inputs. This keeps MemWrite glitch-free for the level-sensitive memory.
- The requester may change req/fields in the cycle after ack; a req still high in the next IDLE is a new transaction.

## Timing
- Reset values: all ack/err = 0, rdata = 0, MemRead = 0, MemWrite = 0, mem_addr = 0, mem_wdata = 0, busy = 0, grant = 0, state IDLE, pointer = 1.
- Latency is measured from the IDLE cycle in which req is sampled (cycle 0):
  - load: ack in cycle 2;
  - store: MemWrite in cycle 2, ack in cycle 3;
  - error: ack in cycle 1.
- Throughput, single port back-to-back: load every 3 cycles, store every 4.
- Simultaneous reqs: the winner completes fully before the loser is granted; the loser waits through all of the winner's states.
- Reset asserted in any state takes effect at the next edge:
  - state → IDLE, MemWrite/MemRead deasserted;
  - no ack for the aborted transaction; a store aborted before WRITE leaves memory unchanged.
- A req arriving while busy is not sampled until IDLE; no request is lost, because req is held.

## Test plan
- Word store then load, port 0: store 0xDEADBEEF at addr 0x010 → MemWrite for one cycle with mem_addr = 4, ack in cycle 3; then a word load at 0x010 → rdata = 0xDEADBEEF, ack in cycle 2.
- Byte RMW: word 0x11223344 at addr 0x020; byte store 0xAB at 0x022 → memory word 0x11AB3344. A signed byte load at 0x022 → 0xFFFFFFAB; an unsigned byte load → 0x000000AB.
- Half load: word 0x80017FFF at 0x030; signed half at 0x032 → 0xFFFF8001; signed half at 0x030 → 0x00007FFF.
- Arbitration, FIXED_PRIO = 0: both ports request repeatedly from reset → grants alternate 0, 1, 0, 1, with no ack lost. With FIXED_PRIO = 1 and port 0 held → port 1 is granted only after port 0 drops req.
- Errors: half at 0x041, word at 0x042, size = 11 → each gives ack with err = 1 one cycle after sampling, rdata = 0, no MemRead or MemWrite.
- Reset mid-op: store of 0x55 to a word holding 0x00000000, with rst_n low during ACCESS → no MemWrite, no ack, memory word still 0, outputs at reset values. A repeated request then completes normally.
